// File: rtl/read_test_sequencer.sv
// rtl/read_test_sequencer.sv - sequences one pipe-out throughput run: flush, meter words, drain, time
module read_test_sequencer #(
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        okClk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] xfer_words,
  input  logic        fifo_almost_full,
  input  logic        gen_valid,
  input  logic        pipe_out_read,
  output logic        gen_enable,
  output logic        gen_reset,
  output logic        fifo_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] run_cycles,
  output logic [31:0] words_written,
  output logic [31:0] words_read,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] written_q, written_d;
  logic [31:0] read_q, read_d;
  logic [31:0] flush_q, flush_d;
  logic [31:0] prog_q, prog_d;
  logic [63:0] cycles_q, cycles_d;
  logic        gen_enable_q, gen_enable_d;
  logic        flush_rst_q, flush_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        active;
  logic        abort_taken;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    issued_d    = issued_q;
    written_d   = written_q;
    read_d      = read_q;
    flush_d     = flush_q;
    prog_d      = '0;
    cycles_d    = cycles_q;
    done_d      = done_q;
    error_d     = error_q;
    active      = (state_q == S_RUN) || (state_q == S_DRAIN);
    abort_taken = abort && (state_q != S_IDLE);

    if (abort_taken) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      if (active) begin
        cycles_d = cycles_q + 64'd1;
        issued_d = issued_q + {31'd0, gen_enable_q};
        prog_d   = (gen_valid || pipe_out_read) ? '0 : prog_q + 32'd1;
        // Writes past the target and reads of an empty FIFO flag error but are not counted
        if (gen_valid) begin
          if (written_q == target_q) error_d = 1'b1;
          else written_d = written_q + 32'd1;
        end
        if (pipe_out_read) begin
          if (read_q == written_q) error_d = 1'b1;
          else read_d = read_q + 32'd1;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_FLUSH;
            target_d  = xfer_words;
            issued_d  = '0;
            written_d = '0;
            read_d    = '0;
            cycles_d  = '0;
            flush_d   = '0;
            done_d    = 1'b0;
            error_d   = 1'b0;
          end
        end
        S_FLUSH: begin
          if (flush_q == FLUSH_CYCLES - 1) begin
            if (target_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            flush_d = flush_q + 32'd1;
          end
        end
        S_RUN: begin
          if (written_d == target_q) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (read_d == target_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (active && prog_d == TIMEOUT_CYCLES) begin
        state_d = S_DONE;
        error_d = 1'b1;
      end
    end

    // issued_d already includes the current enable cycle, so high cycles total exactly target
    gen_enable_d = (state_d == S_RUN) && (issued_d < target_d) && !fifo_almost_full;
    flush_rst_d  = (state_d == S_FLUSH) || abort_taken;
    busy_d       = (state_d == S_FLUSH) || (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      issued_q     <= '0;
      written_q    <= '0;
      read_q       <= '0;
      flush_q      <= '0;
      prog_q       <= '0;
      cycles_q     <= '0;
      gen_enable_q <= 1'b0;
      flush_rst_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      issued_q     <= issued_d;
      written_q    <= written_d;
      read_q       <= read_d;
      flush_q      <= flush_d;
      prog_q       <= prog_d;
      cycles_q     <= cycles_d;
      gen_enable_q <= gen_enable_d;
      flush_rst_q  <= flush_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign gen_enable    = gen_enable_q;
  assign gen_reset     = flush_rst_q;
  assign fifo_reset    = flush_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign run_cycles    = cycles_q;
  assign words_written = written_q;
  assign words_read    = read_q;
  assign state         = state_q;

endmodule
